// File: rtl/pipelined_bit_counter_if.sv
// Beat-level bus of the pipelined bit counter: upstream valid/ready input side
// and downstream valid/ready result side.
interface pipelined_bit_counter_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    out_count;
  logic [ACC_W-1:0] out_total;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_count, out_total, out_last, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_count, out_total, out_last, out_valid
  );
endinterface

// File: rtl/pipelined_bit_counter.sv
// Pipelined population counter: registered pairwise adder tree, one level per
// stage, with a saturating per-frame running total applied at the last stage.
module pipelined_bit_counter #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_bit_counter_if.slave  bus
);
  localparam int D    = $clog2(WIDTH);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NPAD = 1 << D;

  logic             w_adv;
  logic [NPAD-1:0]  w_pad;
  logic [D:0]       w_vin;
  logic [D:0]       w_lin;
  logic [D:1]       r_vld;
  logic [D:1]       r_lst;
  logic [ACC_W-1:0] r_acc;
  logic             r_fs;
  logic [ACC_W-1:0] w_base;
  logic [CW-1:0]    w_cnt;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [CW-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - CW){1'b0}}, b};
    if (s[ACC_W]) begin
      sat_add = '1;
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  assign w_adv        = bus.out_ready | ~r_vld[D];
  assign bus.in_ready = w_adv;
  // Stage index 0 is the input port; a bubble never carries a last flag.
  assign w_vin = {r_vld, bus.in_valid};
  assign w_lin = {r_lst, bus.in_valid & bus.in_last};

  // Zero-pad to a power of two; bubble data is forced to zero so it cannot leak X.
  always_comb begin
    w_pad = '0;
    if (bus.in_valid) begin
      w_pad[WIDTH-1:0] = bus.in_data;
    end else begin
      w_pad = '0;
    end
  end

  for (genvar l = 1; l <= D; l++) begin : g_lvl
    localparam int N = NPAD >> l;
    localparam int W = l + 1;

    logic [2*N*l-1:0] w_prev;
    logic [N*W-1:0]   w_next;
    logic [N*W-1:0]   r_sum;

    if (l == 1) begin : g_first
      assign w_prev = w_pad;
    end else begin : g_rest
      assign w_prev = g_lvl[l-1].r_sum;
    end

    // Pairwise sums, each result one bit wider than its operands.
    always_comb begin
      w_next = '0;
      for (int j = 0; j < N; j++) begin
        w_next[j*W +: W] = {1'b0, w_prev[2*j*l +: l]} + {1'b0, w_prev[(2*j+1)*l +: l]};
      end
    end

    // Level register, advancing in lock-step with the whole pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum <= '0;
      end else if (w_adv) begin
        r_sum <= w_next;
      end else begin
        r_sum <= r_sum;
      end
    end
  end

  assign w_cnt  = g_lvl[D].w_next[CW-1:0];
  assign w_base = r_fs ? '0 : r_acc;

  // Per-stage valid and last flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
    end else if (w_adv) begin
      r_vld <= w_vin[D-1:0];
      r_lst <= w_lin[D-1:0];
    end else begin
      r_vld <= r_vld;
      r_lst <= r_lst;
    end
  end

  // Running total updates only when a real beat enters the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_fs  <= 1'b1;
    end else if (w_adv && w_vin[D-1]) begin
      r_acc <= sat_add(w_base, w_cnt);
      r_fs  <= w_lin[D-1];
    end else begin
      r_acc <= r_acc;
      r_fs  <= r_fs;
    end
  end

  assign bus.out_count = g_lvl[D].r_sum[CW-1:0];
  assign bus.out_total = r_acc;
  assign bus.out_last  = r_lst[D];
  assign bus.out_valid = r_vld[D];
endmodule

// File: tb/tb_pipelined_bit_counter.sv
// Drives three counter instances (8/16, 8/5 saturating, 13/16) with directed and
// random beats and checks them against a beat-level reference model.
module tb_pipelined_bit_counter;
  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic        vld [3];
  logic        lst [3];
  logic [31:0] dat [3];

  int n_cmp = 0;
  int n_err = 0;

  const int dep  [3] = '{3, 3, 4};
  const int wid  [3] = '{8, 8, 13};
  const int amax [3] = '{65535, 31, 65535};

  // Reference model: pending beats per instance and the D-deep occupancy line.
  int q_d [3][$];
  bit q_l [3][$];
  bit m_v [3][4];
  int m_c [3][4];
  int m_t [3][4];
  bit m_l [3][4];
  int m_acc [3];
  bit m_fs  [3];

  int ov [3], oc [3], ot [3], ol [3], ordy [3];

  always #5 clk = ~clk;

  pipelined_bit_counter_if #(.WIDTH(8),  .ACC_W(16)) if_a ();
  pipelined_bit_counter_if #(.WIDTH(8),  .ACC_W(5))  if_b ();
  pipelined_bit_counter_if #(.WIDTH(13), .ACC_W(16)) if_c ();

  assign if_a.in_data = dat[0][7:0];
  assign if_b.in_data = dat[1][7:0];
  assign if_c.in_data = dat[2][12:0];
  assign if_a.in_last = lst[0];
  assign if_b.in_last = lst[1];
  assign if_c.in_last = lst[2];
  assign if_a.in_valid = vld[0];
  assign if_b.in_valid = vld[1];
  assign if_c.in_valid = vld[2];
  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;
  assign if_c.out_ready = rdy;

  pipelined_bit_counter #(.WIDTH(8),  .ACC_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  pipelined_bit_counter #(.WIDTH(8),  .ACC_W(5))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  pipelined_bit_counter #(.WIDTH(13), .ACC_W(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  task automatic chk(input string tag, input int i, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, i, obs, exp);
    end
  endtask

  task automatic sample();
    ov[0] = int'(if_a.out_valid); oc[0] = int'(if_a.out_count); ot[0] = int'(if_a.out_total);
    ol[0] = int'(if_a.out_last);  ordy[0] = int'(if_a.in_ready);
    ov[1] = int'(if_b.out_valid); oc[1] = int'(if_b.out_count); ot[1] = int'(if_b.out_total);
    ol[1] = int'(if_b.out_last);  ordy[1] = int'(if_b.in_ready);
    ov[2] = int'(if_c.out_valid); oc[2] = int'(if_c.out_count); ot[2] = int'(if_c.out_total);
    ol[2] = int'(if_c.out_last);  ordy[2] = int'(if_c.in_ready);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 4; s++) begin
        m_v[i][s] = 1'b0; m_c[i][s] = 0; m_t[i][s] = 0; m_l[i][s] = 1'b0;
      end
      m_acc[i] = 0;
      m_fs[i]  = 1'b1;
      q_d[i].delete();
      q_l[i].delete();
      vld[i] = 1'b0;
    end
  endtask

  task automatic push(input int i, input int d, input bit l);
    q_d[i].push_back(d);
    q_l[i].push_back(l);
  endtask

  task automatic chk_zero(input string tag);
    sample();
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_valid"}, i, ov[i], 0);
      chk({tag, "_count"}, i, oc[i], 0);
      chk({tag, "_total"}, i, ot[i], 0);
      chk({tag, "_last"},  i, ol[i], 0);
    end
  endtask

  // One clock: present head-of-queue beats, check ready, advance model, check outputs.
  task automatic cycle(input bit vld_en, input bit r);
    bit adv [3];
    rdy = r;
    for (int i = 0; i < 3; i++) begin
      if (vld_en && q_d[i].size() > 0) begin
        vld[i] = 1'b1; dat[i] = q_d[i][0]; lst[i] = q_l[i][0];
      end else begin
        vld[i] = 1'b0; dat[i] = $urandom; lst[i] = 1'($urandom);
      end
    end
    #3;
    sample();
    for (int i = 0; i < 3; i++) begin
      adv[i] = r | ~m_v[i][dep[i]-1];
      chk("in_ready", i, ordy[i], int'(adv[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (adv[i]) begin
        for (int s = dep[i] - 1; s >= 1; s--) begin
          m_v[i][s] = m_v[i][s-1]; m_c[i][s] = m_c[i][s-1];
          m_t[i][s] = m_t[i][s-1]; m_l[i][s] = m_l[i][s-1];
        end
        if (vld[i]) begin
          int c, t;
          c = $countones(dat[i] & ((32'd1 << wid[i]) - 32'd1));
          t = (m_fs[i] ? 0 : m_acc[i]) + c;
          if (t > amax[i]) t = amax[i];
          m_acc[i] = t;
          m_fs[i]  = lst[i];
          m_v[i][0] = 1'b1; m_c[i][0] = c; m_t[i][0] = t; m_l[i][0] = lst[i];
          void'(q_d[i].pop_front());
          void'(q_l[i].pop_front());
        end else begin
          m_v[i][0] = 1'b0; m_c[i][0] = 0; m_t[i][0] = 0; m_l[i][0] = 1'b0;
        end
      end
    end
    #1;
    sample();
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, ov[i], int'(m_v[i][dep[i]-1]));
      if (m_v[i][dep[i]-1]) begin
        chk("out_count", i, oc[i], m_c[i][dep[i]-1]);
        chk("out_total", i, ot[i], m_t[i][dep[i]-1]);
        chk("out_last",  i, ol[i], int'(m_l[i][dep[i]-1]));
      end
    end
  endtask

  initial begin
    int t1 [4] = '{32'h00, 32'hFF, 32'hA5, 32'h01};
    int t2 [4] = '{32'h0F, 32'h03, 32'h80, 32'hFF};
    bit l2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0;
    rdy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dat[i] = 32'd0; lst[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    for (int i = 0; i < 3; i++) chk("reset_in_ready", i, ordy[i], 1);
    #2 rst_n = 1'b1;

    // Single-beat frames back-to-back.
    for (int k = 0; k < 4; k++) begin
      push(0, t1[k], 1'b1); push(1, t1[k], 1'b1); push(2, int'($urandom), 1'b1);
    end
    repeat (8) cycle(1'b1, 1'b1);

    // Multi-beat frame followed by a new single-beat frame.
    for (int k = 0; k < 4; k++) begin
      push(0, t2[k], l2[k]); push(1, t2[k], l2[k]); push(2, int'($urandom), l2[k]);
    end
    repeat (8) cycle(1'b1, 1'b1);

    // Backpressure in the middle of a five-beat stream.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) push(i, int'($urandom), 1'($urandom));
    end
    repeat (2) cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b1, 1'b1);

    // Saturating frame of five all-ones beats, then a fresh frame.
    for (int k = 0; k < 5; k++) begin
      push(0, 32'hFF, k == 4); push(1, 32'hFF, k == 4); push(2, int'($urandom), k == 4);
    end
    push(0, 32'h01, 1'b1); push(1, 32'h01, 1'b1); push(2, 32'h01, 1'b1);
    repeat (12) cycle(1'b1, 1'b1);

    // Thirteen-bit corner patterns.
    push(2, 32'h1FFF, 1'b1); push(2, 32'h1001, 1'b1);
    push(0, int'($urandom), 1'b1); push(1, int'($urandom), 1'b1);
    repeat (8) cycle(1'b1, 1'b1);

    // Random traffic with random bubbles and stalls.
    repeat (300) begin
      for (int i = 0; i < 3; i++) begin
        if (q_d[i].size() < 4) push(i, int'($urandom), ($urandom_range(0, 2) == 0));
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (24) cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) chk("drain", i, q_d[i].size(), 0);

    // Asynchronous reset with beats in flight and a partial frame total of 5.
    for (int i = 0; i < 3; i++) begin
      push(i, 32'h00, 1'b1); push(i, 32'h1F, 1'b0); push(i, 32'h03, 1'b0); push(i, 32'h03, 1'b0);
    end
    repeat (4) cycle(1'b1, 1'b1);
    sample();
    chk("pre_reset_total", 0, ot[0], 5);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push(i, 32'h03, 1'b1);
    repeat (6) cycle(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
